// File: rtl/vending_machine_param.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_param
//  Description : Parametrised vending-machine core. Accepts coin credit,
//                navigates a product selection, dispenses the selected item
//                for a fixed pulse length, and refunds change on cancel
//                (and optionally after each dispense).
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module vending_machine_param #(
    parameter int                         NUM_ITEMS       = 4,
    parameter int                         BAL_W           = 6,
    parameter int                         MAX_BALANCE     = 63,
    parameter int                         C_VALUE         = 5,
    parameter int                         U_VALUE         = 1,
    parameter logic [NUM_ITEMS*BAL_W-1:0] PRICES          = {6'd10, 6'd20, 6'd25, 6'd30},
    parameter int                         LED_W           = 10,
    parameter int                         LED_STEP        = 5,
    parameter int                         DISPENSE_CYCLES = 4,
    parameter int                         AUTO_CHANGE     = 0,
    localparam int                        SEL_W           = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 c,
    input  logic                 u,
    input  logic                 cima,
    input  logic                 baixo,
    input  logic                 enter,
    input  logic                 cancelar,
    output logic [SEL_W-1:0]     sel,
    output logic [BAL_W-1:0]     saldo,
    output logic [LED_W-1:0]     led,
    output logic [NUM_ITEMS-1:0] produto,
    output logic                 sucesso,
    output logic [BAL_W-1:0]     troco,
    output logic                 troco_valid
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_DISPENSE = 1'b1
    } state_t;

    localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] c_DISP_LOAD = CNT_W'(DISPENSE_CYCLES);
    localparam logic [CNT_W-1:0] c_DISP_LAST = CNT_W'(1);
    localparam logic [BAL_W:0]   c_C_VAL     = (BAL_W + 1)'(C_VALUE);
    localparam logic [BAL_W:0]   c_U_VAL     = (BAL_W + 1)'(U_VALUE);
    localparam logic [BAL_W:0]   c_MAX_BAL   = (BAL_W + 1)'(MAX_BALANCE);
    localparam logic [SEL_W-1:0] c_SEL_LAST  = SEL_W'(NUM_ITEMS - 1);

    // Button vector order: {cancelar, enter, baixo, cima, u, c}
    localparam int c_B_C     = 0;
    localparam int c_B_U     = 1;
    localparam int c_B_CIMA  = 2;
    localparam int c_B_BAIXO = 3;
    localparam int c_B_ENTER = 4;
    localparam int c_B_CANC  = 5;

    state_t                 r_state;
    logic [SEL_W-1:0]       r_sel;
    logic [BAL_W-1:0]       r_saldo;
    logic [NUM_ITEMS-1:0]   r_produto;
    logic                   r_sucesso;
    logic [BAL_W-1:0]       r_troco;
    logic                   r_troco_valid;
    logic [CNT_W-1:0]       r_cnt;
    logic [5:0]             r_btn_q;

    state_t                 w_state_nxt;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic [BAL_W-1:0]       w_saldo_nxt;
    logic [NUM_ITEMS-1:0]   w_produto_nxt;
    logic                   w_sucesso_nxt;
    logic [BAL_W-1:0]       w_troco_nxt;
    logic                   w_troco_valid_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    logic [5:0]             w_btn;
    logic [5:0]             w_rise;
    logic [BAL_W:0]         w_coin_val;
    logic [BAL_W:0]         w_coin_sum;
    logic [BAL_W-1:0]       w_price;
    logic [NUM_ITEMS-1:0]   w_onehot;
    logic [BAL_W-1:0]       w_price_tbl [NUM_ITEMS];
    logic [31:0]            w_saldo_ext;

    assign w_btn  = {cancelar, enter, baixo, cima, u, c};
    // An event is a 0->1 transition relative to the previous clock's sample
    assign w_rise = w_btn & ~r_btn_q;

    // Both coin buttons rising together credit their sum as a single event
    assign w_coin_val = (w_rise[c_B_C] ? c_C_VAL : '0) + (w_rise[c_B_U] ? c_U_VAL : '0);
    assign w_coin_sum = {1'b0, r_saldo} + w_coin_val;

    generate
        for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
            assign w_price_tbl[i] = PRICES[i*BAL_W +: BAL_W];
        end
    endgenerate

    assign w_price  = w_price_tbl[r_sel];
    assign w_onehot = NUM_ITEMS'(1) << r_sel;

    // Next-state and output decode; only the highest-priority event acts
    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_saldo_nxt       = r_saldo;
        w_produto_nxt     = r_produto;
        w_sucesso_nxt     = r_sucesso;
        w_troco_nxt       = r_troco;
        w_troco_valid_nxt = 1'b0;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_rise[c_B_CANC]) begin
                    if (r_saldo != '0) begin
                        w_troco_nxt       = r_saldo;
                        w_troco_valid_nxt = 1'b1;
                        w_saldo_nxt       = '0;
                    end
                    w_sucesso_nxt = 1'b1;
                end else if (w_rise[c_B_ENTER]) begin
                    if (r_saldo >= w_price) begin
                        w_saldo_nxt   = r_saldo - w_price;
                        w_produto_nxt = w_onehot;
                        w_sucesso_nxt = 1'b1;
                        w_cnt_nxt     = c_DISP_LOAD;
                        w_state_nxt   = S_DISPENSE;
                    end else begin
                        w_sucesso_nxt = 1'b0;
                    end
                end else if (w_rise[c_B_C] || w_rise[c_B_U]) begin
                    if (w_coin_sum <= c_MAX_BAL) begin
                        w_saldo_nxt   = w_coin_sum[BAL_W-1:0];
                        w_sucesso_nxt = 1'b1;
                    end else begin
                        w_sucesso_nxt = 1'b0;
                    end
                end else if (w_rise[c_B_CIMA] && !w_rise[c_B_BAIXO]) begin
                    w_sel_nxt = (r_sel == c_SEL_LAST) ? '0 : r_sel + SEL_W'(1);
                end else if (w_rise[c_B_BAIXO] && !w_rise[c_B_CIMA]) begin
                    w_sel_nxt = (r_sel == '0) ? c_SEL_LAST : r_sel - SEL_W'(1);
                end
            end

            S_DISPENSE: begin
                // Buttons are ignored here; the counter alone times the pulse
                if (r_cnt == c_DISP_LAST) begin
                    w_produto_nxt = '0;
                    w_state_nxt   = S_IDLE;
                    if ((AUTO_CHANGE != 0) && (r_saldo != '0)) begin
                        w_troco_nxt       = r_saldo;
                        w_troco_valid_nxt = 1'b1;
                        w_saldo_nxt       = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_produto_nxt = '0;
            end
        endcase
    end

    // State register; button history keeps tracking even while dispensing
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_saldo       <= '0;
            r_produto     <= '0;
            r_sucesso     <= 1'b0;
            r_troco       <= '0;
            r_troco_valid <= 1'b0;
            r_cnt         <= '0;
            r_btn_q       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_saldo       <= w_saldo_nxt;
            r_produto     <= w_produto_nxt;
            r_sucesso     <= w_sucesso_nxt;
            r_troco       <= w_troco_nxt;
            r_troco_valid <= w_troco_valid_nxt;
            r_cnt         <= w_cnt_nxt;
            r_btn_q       <= w_btn;
        end
    end

    // Thermometer bargraph: LED k lights once the balance reaches (k+1) steps
    assign w_saldo_ext = 32'(r_saldo);

    generate
        for (genvar k = 0; k < LED_W; k++) begin : g_led
            localparam logic [31:0] c_THR = 32'((k + 1) * LED_STEP);
            assign led[k] = (w_saldo_ext >= c_THR);
        end
    endgenerate

    assign sel         = r_sel;
    assign saldo       = r_saldo;
    assign produto     = r_produto;
    assign sucesso     = r_sucesso;
    assign troco       = r_troco;
    assign troco_valid = r_troco_valid;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_machine_param
//  Description : Self-checking bench for vending_machine_param. Two instances
//                (without and with automatic change) share one stimulus
//                stream and are compared every cycle against a behavioural
//                model, plus directed checks of the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_param;

    localparam logic [5:0] B_C    = 6'b000001;
    localparam logic [5:0] B_U    = 6'b000010;
    localparam logic [5:0] B_CIMA = 6'b000100;
    localparam logic [5:0] B_BAIX = 6'b001000;
    localparam logic [5:0] B_ENT  = 6'b010000;
    localparam logic [5:0] B_CANC = 6'b100000;

    logic clock = 1'b0;
    logic reset, c, u, cima, baixo, enter, cancelar;

    logic [1:0] sel0, sel1;
    logic [5:0] saldo0, saldo1, troco0, troco1;
    logic [9:0] led0, led1;
    logic [3:0] produto0, produto1;
    logic       sucesso0, sucesso1, tv0, tv1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    vending_machine_param #(.AUTO_CHANGE(0)) dut0 (
        .clock(clock), .reset(reset), .c(c), .u(u), .cima(cima), .baixo(baixo),
        .enter(enter), .cancelar(cancelar), .sel(sel0), .saldo(saldo0), .led(led0),
        .produto(produto0), .sucesso(sucesso0), .troco(troco0), .troco_valid(tv0)
    );

    vending_machine_param #(.AUTO_CHANGE(1)) dut1 (
        .clock(clock), .reset(reset), .c(c), .u(u), .cima(cima), .baixo(baixo),
        .enter(enter), .cancelar(cancelar), .sel(sel1), .saldo(saldo1), .led(led1),
        .produto(produto1), .sucesso(sucesso1), .troco(troco1), .troco_valid(tv1)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int saldo;
        int sel;
        int prod;   // dispensing item index, -1 when idle
        int left;   // dispense cycles still to run
        bit suc;
        int troco;
        bit tv;
    } mdl_t;

    int         price_tab [4] = '{30, 25, 20, 10};
    mdl_t       m0, m1;
    logic [5:0] prev;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.saldo = 0; z.sel = 0; z.prod = -1; z.left = 0;
        z.suc = 0; z.troco = 0; z.tv = 0;
        return z;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, logic [5:0] r, bit autoc);
        mdl_t n;
        int   v;
        n    = s;
        n.tv = 0;
        if (s.left > 0) begin
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.prod = -1;
                if (autoc && s.saldo > 0) begin
                    n.troco = s.saldo; n.tv = 1; n.saldo = 0;
                end
            end
        end else if (r[5]) begin
            if (s.saldo > 0) begin
                n.troco = s.saldo; n.tv = 1; n.saldo = 0;
            end
            n.suc = 1;
        end else if (r[4]) begin
            if (s.saldo >= price_tab[s.sel]) begin
                n.saldo = s.saldo - price_tab[s.sel];
                n.prod  = s.sel;
                n.left  = 4;
                n.suc   = 1;
            end else begin
                n.suc = 0;
            end
        end else if (r[0] || r[1]) begin
            v = (r[0] ? 5 : 0) + (r[1] ? 1 : 0);
            if (s.saldo + v <= 63) begin
                n.saldo = s.saldo + v; n.suc = 1;
            end else begin
                n.suc = 0;
            end
        end else if (r[2] && !r[3]) begin
            n.sel = (s.sel + 1) % 4;
        end else if (r[3] && !r[2]) begin
            n.sel = (s.sel + 3) % 4;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_led(int s);
        int n;
        n = s / 5;
        if (n > 10) n = 10;
        return 32'((1 << n) - 1);
    endfunction

    function automatic logic [31:0] exp_prod(int p);
        return (p < 0) ? 32'd0 : 32'(1 << p);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sel0",     32'(sel0),     32'(m0.sel));
        chk("saldo0",   32'(saldo0),   32'(m0.saldo));
        chk("led0",     32'(led0),     exp_led(m0.saldo));
        chk("produto0", 32'(produto0), exp_prod(m0.prod));
        chk("sucesso0", 32'(sucesso0), 32'(m0.suc));
        chk("troco0",   32'(troco0),   32'(m0.troco));
        chk("tv0",      32'(tv0),      32'(m0.tv));
        chk("sel1",     32'(sel1),     32'(m1.sel));
        chk("saldo1",   32'(saldo1),   32'(m1.saldo));
        chk("led1",     32'(led1),     exp_led(m1.saldo));
        chk("produto1", 32'(produto1), exp_prod(m1.prod));
        chk("sucesso1", 32'(sucesso1), 32'(m1.suc));
        chk("troco1",   32'(troco1),   32'(m1.troco));
        chk("tv1",      32'(tv1),      32'(m1.tv));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge
    task automatic tick(input logic [5:0] b, input logic r);
        logic [5:0] rise;
        {cancelar, enter, baixo, cima, u, c} = b;
        reset = r;
        @(posedge clock);
        if (r) begin
            m0 = mdl_zero(); m1 = mdl_zero(); prev = '0;
        end else begin
            rise = b & ~prev;
            m0   = mdl_step(m0, rise, 1'b0);
            m1   = mdl_step(m1, rise, 1'b1);
            prev = b;
        end
        @(negedge clock);
        check_all();
    endtask

    task automatic press(input logic [5:0] b, input int times);
        for (int i = 0; i < times; i++) begin
            tick(b, 1'b0);
            tick(6'd0, 1'b0);
        end
    endtask

    initial begin
        logic [5:0] rb;
        logic       rr;
        m0 = mdl_zero(); m1 = mdl_zero(); prev = '0;

        // Reset state
        tick(6'd0, 1'b1);
        tick(6'd0, 1'b1);
        chk("rst_saldo", 32'(saldo0), 0);
        chk("rst_sel",   32'(sel0),   0);
        chk("rst_led",   32'(led0),   0);
        chk("rst_prod",  32'(produto0), 0);
        chk("rst_tv",    32'(tv0),    0);

        // Ten c presses fill the bargraph one LED at a time
        for (int k = 1; k <= 10; k++) begin
            tick(B_C, 1'b0);
            chk("c_saldo", 32'(saldo0), 32'(5 * k));
            chk("c_led",   32'(led0[k-1]), 1);
            chk("c_suc",   32'(sucesso0), 1);
            tick(6'd0, 1'b0);
        end
        chk("led_full", 32'(led0), 32'h3FF);
        chk("saldo50",  32'(saldo0), 50);

        // Overflow rejection then fill to the limit with u
        press(B_C, 2);
        tick(B_C, 1'b0);
        chk("ovf_saldo", 32'(saldo0), 60);
        chk("ovf_suc",   32'(sucesso0), 0);
        tick(6'd0, 1'b0);
        press(B_U, 3);
        chk("u_saldo63", 32'(saldo0), 63);
        chk("u_suc",     32'(sucesso0), 1);

        // Cancel refund
        tick(B_CANC, 1'b0);
        chk("canc_troco", 32'(troco0), 63);
        chk("canc_tv",    32'(tv0), 1);
        tick(6'd0, 1'b0);
        chk("canc_tv_off", 32'(tv0), 0);
        chk("canc_keep",   32'(troco0), 63);

        // Selection wrap
        press(B_CIMA, 3);
        chk("sel3", 32'(sel0), 3);
        press(B_CIMA, 1);
        chk("sel_wrap_up", 32'(sel0), 0);
        press(B_BAIX, 1);
        chk("sel_wrap_dn", 32'(sel0), 3);
        tick(B_CIMA | B_BAIX, 1'b0);
        chk("sel_both", 32'(sel0), 3);
        tick(6'd0, 1'b0);

        // Purchase soda (item 3) from 50
        press(B_C, 10);
        tick(B_ENT, 1'b0);
        chk("buy_prod", 32'(produto0), 32'h8);
        chk("buy_saldo", 32'(saldo0), 40);
        chk("buy_suc", 32'(sucesso0), 1);
        for (int i = 0; i < 3; i++) begin
            tick(6'd0, 1'b0);
            chk("buy_hold", 32'(produto0), 32'h8);
        end
        tick(6'd0, 1'b0);
        chk("buy_end", 32'(produto0), 0);
        chk("auto_troco40", 32'(troco1), 40);
        chk("auto_tv40", 32'(tv1), 1);

        // Enter held for ten cycles buys once
        for (int i = 0; i < 10; i++) tick(B_ENT, 1'b0);
        tick(6'd0, 1'b0);
        chk("held_enter", 32'(saldo0), 30);

        // Automatic change after buying item 1
        press(B_CANC, 1);
        press(B_C, 10);
        press(B_BAIX, 2);
        chk("sel1", 32'(sel1), 1);
        tick(B_ENT, 1'b0);
        chk("auto_prod", 32'(produto1), 32'h2);
        for (int i = 0; i < 3; i++) tick(6'd0, 1'b0);
        chk("auto_prod_hold", 32'(produto1), 32'h2);
        tick(6'd0, 1'b0);
        chk("auto_troco", 32'(troco1), 25);
        chk("auto_tv",    32'(tv1), 1);
        chk("auto_saldo", 32'(saldo1), 0);
        chk("auto_prod_off", 32'(produto1), 0);
        chk("noauto_saldo", 32'(saldo0), 25);
        tick(6'd0, 1'b0);
        chk("auto_tv_off", 32'(tv1), 0);

        // Insufficient balance for pizza
        press(B_CANC, 1);
        press(B_C, 1);
        press(B_BAIX, 1);
        tick(B_ENT, 1'b0);
        chk("poor_suc",   32'(sucesso0), 0);
        chk("poor_saldo", 32'(saldo0), 5);
        chk("poor_prod",  32'(produto0), 0);
        tick(6'd0, 1'b0);

        // Cancel beats a coin in the same cycle
        press(B_C, 6);
        tick(B_CANC | B_C, 1'b0);
        chk("cc_troco", 32'(troco0), 35);
        chk("cc_tv",    32'(tv0), 1);
        chk("cc_saldo", 32'(saldo0), 0);
        tick(6'd0, 1'b0);

        // Reset in the second dispense cycle
        press(B_C, 6);
        tick(B_ENT, 1'b0);
        chk("rd_prod", 32'(produto0), 32'h1);
        tick(6'd0, 1'b0);
        tick(6'd0, 1'b1);
        chk("rd_prod0",  32'(produto0), 0);
        chk("rd_saldo0", 32'(saldo0), 0);
        chk("rd_suc0",   32'(sucesso0), 0);
        chk("rd_led0",   32'(led0), 0);
        tick(6'd0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rb = '0;
            rb[0] = ($urandom_range(0, 3) == 0);
            rb[1] = ($urandom_range(0, 3) == 0);
            rb[2] = ($urandom_range(0, 5) == 0);
            rb[3] = ($urandom_range(0, 5) == 0);
            rb[4] = ($urandom_range(0, 7) == 0);
            rb[5] = ($urandom_range(0, 39) == 0);
            rr    = ($urandom_range(0, 299) == 0);
            tick(rb, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
